// File: rtl/fetch_unit_if.sv
// Fetch-stage ports: Sysbus line reads plus the instruction handshake to the decoder.
// master = fetch unit side, slave = bus/decoder side.
`ifndef SYSBUS_READ
`define SYSBUS_READ 1'b1
`endif
`ifndef SYSBUS_MEMORY
`define SYSBUS_MEMORY 4'b0001
`endif

interface fetch_unit_if #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13
);
  logic                      bus_reqcyc;
  logic                      bus_reqack;
  logic [BUS_DATA_WIDTH-1:0] bus_req;
  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag;
  logic                      bus_respcyc;
  logic                      bus_respack;
  logic [BUS_DATA_WIDTH-1:0] bus_resp;
  logic [BUS_TAG_WIDTH-1:0]  bus_resptag;
  logic                      inst_valid;
  logic                      inst_ready;
  logic [31:0]               inst;
  logic [63:0]               inst_pc;

  modport master (
    output bus_reqcyc, bus_req, bus_reqtag, bus_respack, inst_valid, inst, inst_pc,
    input  bus_reqack, bus_respcyc, bus_resp, bus_resptag, inst_ready
  );

  modport slave (
    input  bus_reqcyc, bus_req, bus_reqtag, bus_respack, inst_valid, inst, inst_pc,
    output bus_reqack, bus_respcyc, bus_resp, bus_resptag, inst_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, reads 64-byte lines over Sysbus, buffers them and
// hands 32-bit words to the decoder; supports redirects at any point, including mid-burst.
module fetch_unit #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int LINE_BEATS     = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] entry,
  fetch_unit_if.master bus,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc
);
  localparam int CNT_W = $clog2(LINE_BEATS);

  typedef enum logic [1:0] {
    ST_REQ    = 2'd0,
    ST_RESP   = 2'd1,
    ST_SUPPLY = 2'd2
  } state_t;

  state_t                    state_r, state_nxt_s;
  logic [63:0]               pc_r, pc_nxt_s, pc_inc_s;
  logic                      discard_r, discard_nxt_s;
  logic [CNT_W-1:0]          beat_cnt_r, beat_cnt_nxt_s;
  logic [57:0]               line_tag_r;
  logic                      line_valid_r, line_valid_nxt_s;
  logic                      tag_load_s;
  logic                      line_hit_s;
  logic [BUS_DATA_WIDTH-1:0] line_buf_r [LINE_BEATS];
  logic                      unused_s;

  assign unused_s = ^bus.bus_resptag;

  // State, PC and line bookkeeping registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_REQ;
      pc_r         <= entry;
      discard_r    <= 1'b0;
      beat_cnt_r   <= '0;
      line_tag_r   <= 58'd0;
      line_valid_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      pc_r         <= pc_nxt_s;
      discard_r    <= discard_nxt_s;
      beat_cnt_r   <= beat_cnt_nxt_s;
      line_tag_r   <= tag_load_s ? pc_r[63:6] : line_tag_r;
      line_valid_r <= line_valid_nxt_s;
    end
  end

  // Line buffer fill in beat arrival order; dropped beats land here harmlessly
  always_ff @(posedge clk) begin
    if (state_r == ST_RESP && bus.bus_respcyc) begin
      line_buf_r[beat_cnt_r] <= bus.bus_resp;
    end
  end

  // Next-state logic; redirect outranks the decoder handshake
  always_comb begin
    state_nxt_s      = state_r;
    pc_nxt_s         = pc_r;
    discard_nxt_s    = discard_r;
    beat_cnt_nxt_s   = beat_cnt_r;
    line_valid_nxt_s = line_valid_r;
    tag_load_s       = 1'b0;
    pc_inc_s         = pc_r + 64'd4;
    line_hit_s       = line_valid_r && (redirect_pc[63:6] == line_tag_r);

    case (state_r)
      ST_REQ: begin
        if (redirect_valid) begin
          pc_nxt_s = redirect_pc;
        end else begin
          pc_nxt_s = pc_r;
        end
        if (bus.bus_reqack) begin
          // an ack coinciding with a redirect belongs to the old PC
          state_nxt_s      = ST_RESP;
          beat_cnt_nxt_s   = '0;
          discard_nxt_s    = redirect_valid;
          line_valid_nxt_s = 1'b0;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_RESP: begin
        if (redirect_valid) begin
          pc_nxt_s      = redirect_pc;
          discard_nxt_s = 1'b1;
        end else begin
          pc_nxt_s = pc_r;
        end
        if (bus.bus_respcyc) begin
          beat_cnt_nxt_s = beat_cnt_r + CNT_W'(1);
          if (beat_cnt_r == CNT_W'(LINE_BEATS - 1)) begin
            if (discard_r || redirect_valid) begin
              state_nxt_s   = ST_REQ;
              discard_nxt_s = 1'b0;
            end else begin
              state_nxt_s      = ST_SUPPLY;
              tag_load_s       = 1'b1;
              line_valid_nxt_s = 1'b1;
            end
          end else begin
            state_nxt_s = ST_RESP;
          end
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      ST_SUPPLY: begin
        if (redirect_valid) begin
          pc_nxt_s = redirect_pc;
          if (line_hit_s) begin
            state_nxt_s = ST_SUPPLY;
          end else begin
            state_nxt_s = ST_REQ;
          end
        end else if (bus.inst_ready) begin
          pc_nxt_s = pc_inc_s;
          if (pc_inc_s[5:2] == 4'd0) begin
            state_nxt_s = ST_REQ;
          end else begin
            state_nxt_s = ST_SUPPLY;
          end
        end else begin
          state_nxt_s = ST_SUPPLY;
        end
      end
      default: begin
        state_nxt_s   = ST_REQ;
        discard_nxt_s = 1'b0;
      end
    endcase
  end

  // Outputs decode from registered state; forced low while reset is held
  always_comb begin
    bus.bus_reqcyc  = 1'b0;
    bus.bus_req     = '0;
    bus.bus_reqtag  = '0;
    bus.bus_respack = 1'b0;
    bus.inst_valid  = 1'b0;
    bus.inst        = 32'd0;
    bus.inst_pc     = 64'd0;
    if (reset) begin
      case (state_r)
        ST_REQ: begin
          bus.bus_reqcyc = 1'b1;
          bus.bus_req    = BUS_DATA_WIDTH'({pc_r[63:6], 6'b000000});
          bus.bus_reqtag = BUS_TAG_WIDTH'({`SYSBUS_READ, `SYSBUS_MEMORY, 8'h00});
        end
        ST_RESP: begin
          bus.bus_respack = bus.bus_respcyc;
        end
        ST_SUPPLY: begin
          bus.inst_valid = 1'b1;
          bus.inst       = line_buf_r[pc_r[5:3]][{pc_r[2], 5'b00000} +: 32];
          bus.inst_pc    = pc_r;
        end
        default: begin
          bus.bus_reqcyc = 1'b0;
        end
      endcase
    end else begin
      bus.bus_reqcyc  = 1'b0;
      bus.bus_respack = 1'b0;
      bus.inst_valid  = 1'b0;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a memory model whose word at address a is (a-0x1000)/4.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] entry;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  int          total = 0;
  int          bad = 0;

  localparam logic [12:0] RD_TAG = 13'h1100;

  fetch_unit_if #(.BUS_DATA_WIDTH(64), .BUS_TAG_WIDTH(13)) bus_if ();

  fetch_unit #(.BUS_DATA_WIDTH(64), .BUS_TAG_WIDTH(13), .LINE_BEATS(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .entry          (entry),
    .bus            (bus_if.master),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] entry;
    logic [63:0] req;
    int          count;
    logic [63:0] next_req;
  } vec_t;

  function automatic logic [31:0] word_at(input logic [63:0] a);
    logic [63:0] d;
    d = (a - 64'h1000) >> 2;
    return d[31:0];
  endfunction

  function automatic logic [63:0] beat_at(input logic [63:0] line, input int k);
    logic [63:0] a;
    a = line + 64'(8 * k);
    return {word_at(a + 64'd4), word_at(a)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [63:0] e);
    entry = e;
    reset = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 64'd0;
    bus_if.bus_reqack = 1'b0;
    bus_if.bus_respcyc = 1'b0;
    bus_if.bus_resp = 64'd0;
    bus_if.bus_resptag = 13'd0;
    bus_if.inst_ready = 1'b0;
    #2;
    check("rst_reqcyc", 64'(bus_if.bus_reqcyc), 64'd0);
    check("rst_respack", 64'(bus_if.bus_respack), 64'd0);
    check("rst_valid", 64'(bus_if.inst_valid), 64'd0);
    check("rst_req", bus_if.bus_req, 64'd0);
    check("rst_tag", 64'(bus_if.bus_reqtag), 64'd0);
    check("rst_inst", 64'(bus_if.inst), 64'd0);
    check("rst_pc", bus_if.inst_pc, 64'd0);
    step();
    step();
    reset = 1'b1;
    #1;
  endtask

  // Wait (bounded) for a request, check it is held while unacked, then ack it
  task automatic serve_request(input logic [63:0] exp);
    int n = 0;
    while (bus_if.bus_reqcyc !== 1'b1 && n < 32) begin
      step();
      n++;
    end
    check("req_seen", 64'(bus_if.bus_reqcyc), 64'd1);
    check("req_addr", bus_if.bus_req, exp);
    check("req_tag", 64'(bus_if.bus_reqtag), 64'(RD_TAG));
    step();
    check("req_held", bus_if.bus_req, exp);
    bus_if.bus_reqack = 1'b1;
    step();
    bus_if.bus_reqack = 1'b0;
    check("req_gone", 64'(bus_if.bus_reqcyc), 64'd0);
  endtask

  task automatic send_beats(input logic [63:0] line, input int k0, input int k1);
    for (int k = k0; k <= k1; k++) begin
      bus_if.bus_respcyc = 1'b1;
      bus_if.bus_resp = beat_at(line, k);
      #1;
      check("beat_ack", 64'(bus_if.bus_respack), 64'd1);
      check("resp_novalid", 64'(bus_if.inst_valid), 64'd0);
      step();
    end
    bus_if.bus_respcyc = 1'b0;
    bus_if.bus_resp = 64'd0;
  endtask

  task automatic consume(input logic [63:0] first, input int n);
    logic [63:0] p;
    bus_if.inst_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      p = first + 64'(4 * i);
      check("inst_valid", 64'(bus_if.inst_valid), 64'd1);
      check("inst_pc", bus_if.inst_pc, p);
      check("inst", 64'(bus_if.inst), 64'(word_at(p)));
      step();
    end
    bus_if.inst_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[4];
    vecs[0] = '{64'h1000, 64'h1000, 16, 64'h1040};
    vecs[1] = '{64'h1008, 64'h1000, 14, 64'h1040};
    vecs[2] = '{64'h103C, 64'h1000, 1,  64'h1040};
    vecs[3] = '{64'h1FC0, 64'h1FC0, 16, 64'h2000};

    // Full-line deliveries from several entry points
    for (int v = 0; v < 4; v++) begin
      do_reset(vecs[v].entry);
      serve_request(vecs[v].req);
      send_beats(vecs[v].req, 0, 7);
      consume(vecs[v].entry, vecs[v].count);
      check("next_reqcyc", 64'(bus_if.bus_reqcyc), 64'd1);
      check("next_req", bus_if.bus_req, vecs[v].next_req);
      check("next_novalid", 64'(bus_if.inst_valid), 64'd0);
    end

    // Backpressure: presented instruction held, pc frozen
    do_reset(64'h1000);
    serve_request(64'h1000);
    send_beats(64'h1000, 0, 7);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 64'(bus_if.inst_valid), 64'd1);
      check("bp_pc", bus_if.inst_pc, 64'h1000);
      check("bp_inst", 64'(bus_if.inst), 64'h0);
      step();
    end
    consume(64'h1000, 2);

    // Redirect mid-burst: remaining beats dropped, refetch at new pc
    do_reset(64'h1000);
    serve_request(64'h1000);
    send_beats(64'h1000, 0, 3);
    redirect_valid = 1'b1;
    redirect_pc = 64'h2000;
    step();
    redirect_valid = 1'b0;
    send_beats(64'h1000, 4, 7);
    check("rd_novalid", 64'(bus_if.inst_valid), 64'd0);
    serve_request(64'h2000);
    send_beats(64'h2000, 0, 7);
    consume(64'h2000, 1);

    // Redirect hit inside the buffered line
    do_reset(64'h1000);
    serve_request(64'h1000);
    send_beats(64'h1000, 0, 7);
    consume(64'h1000, 4);
    bus_if.inst_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 64'h1030;
    #1;
    check("hit_cur_pc", bus_if.inst_pc, 64'h1010);
    step();
    redirect_valid = 1'b0;
    bus_if.inst_ready = 1'b0;
    check("hit_noreq", 64'(bus_if.bus_reqcyc), 64'd0);
    check("hit_valid", 64'(bus_if.inst_valid), 64'd1);
    check("hit_pc", bus_if.inst_pc, 64'h1030);
    check("hit_inst", 64'(bus_if.inst), 64'd12);
    consume(64'h1030, 4);
    check("hit_next_req", bus_if.bus_req, 64'h1040);

    // Redirect in REQ: unacked follows pc; acked-with-redirect is stale
    do_reset(64'h1000);
    redirect_valid = 1'b1;
    redirect_pc = 64'h2040;
    step();
    check("rq_follow", bus_if.bus_req, 64'h2040);
    redirect_pc = 64'h3000;
    bus_if.bus_reqack = 1'b1;
    step();
    redirect_valid = 1'b0;
    bus_if.bus_reqack = 1'b0;
    send_beats(64'h2040, 0, 7);
    check("rq_stale_novalid", 64'(bus_if.inst_valid), 64'd0);
    serve_request(64'h3000);
    send_beats(64'h3000, 0, 7);
    consume(64'h3000, 2);

    // Asynchronous reset in the middle of a burst
    do_reset(64'h1000);
    serve_request(64'h1000);
    send_beats(64'h1000, 0, 2);
    bus_if.bus_respcyc = 1'b1;
    bus_if.bus_resp = beat_at(64'h1000, 3);
    #1;
    check("ar_pre_ack", 64'(bus_if.bus_respack), 64'd1);
    entry = 64'h1008;
    reset = 1'b0;
    #1;
    check("ar_respack", 64'(bus_if.bus_respack), 64'd0);
    check("ar_reqcyc", 64'(bus_if.bus_reqcyc), 64'd0);
    check("ar_valid", 64'(bus_if.inst_valid), 64'd0);
    bus_if.bus_respcyc = 1'b0;
    step();
    step();
    reset = 1'b1;
    #1;
    serve_request(64'h1000);
    send_beats(64'h1000, 0, 7);
    consume(64'h1008, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
